// File: rtl/junction_sequencer.sv
// junction_sequencer
//
// Takes the drive H-bridge through a complete junction manoeuvre. It advances past the junction,
// pivots left, right or 180 degrees according to the tone-detector direction, reacquires the
// line, and then hands control back to line following. While busy, mot_l/mot_r override the
// normal drive commands.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   junction        junction detected (level); a rising edge starts a manoeuvre
//   td_en, td_dir   tone direction valid / direction (00 straight, 01 left, 10 right, 11 back)
//   line_c          centre line sensor, 1 = on line
//   abort           collision/abort request (level), brakes and returns to idle
//   busy            sequencer owns the motors
//   done, fault     one-cycle completion / pivot-timeout pulses
//   mot_l, mot_r    wheel commands: 00 brake, 01 forward, 10 reverse
//   dir_q           latched manoeuvre direction
//
// Optional feature: define JSEQ_BRAKE_SETTLE_EN to insert a 30 ms braking SETTLE phase before
// every pivot (after ADVANCE and on the BACK re-pivot).

module junction_sequencer #(
  parameter int unsigned CLK_HZ           = 50_000_000,
  parameter int unsigned ADVANCE_MS       = 200,
  parameter int unsigned MIN_PIVOT_MS     = 150,
  parameter int unsigned PIVOT_TIMEOUT_MS = 2000,
  parameter int unsigned DIR_WAIT_MS      = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       junction,
  input  logic       td_en,
  input  logic [1:0] td_dir,
  input  logic       line_c,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [1:0] mot_l,
  output logic [1:0] mot_r,
  output logic [1:0] dir_q
);

  localparam int unsigned TickCycles = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int unsigned PscW       = (TickCycles > 1) ? $clog2(TickCycles) : 1;
  localparam int unsigned MsW        = 16;

  localparam logic [1:0] DirStraight = 2'b00;
  localparam logic [1:0] DirLeft     = 2'b01;
  localparam logic [1:0] DirBack     = 2'b11;

  localparam logic [1:0] MotBrake = 2'b00;
  localparam logic [1:0] MotFwd   = 2'b01;
  localparam logic [1:0] MotRev   = 2'b10;

`ifdef JSEQ_BRAKE_SETTLE_EN
  localparam int unsigned SettleMs = 30;

  typedef enum logic [2:0] {
    StIdle, StWaitDir, StAdvance, StPivotMin, StPivotSeek, StDone, StFault, StSettle
  } state_t;
`else
  typedef enum logic [2:0] {
    StIdle, StWaitDir, StAdvance, StPivotMin, StPivotSeek, StDone, StFault
  } state_t;
`endif

  state_t          stateQ, stateD;
  logic [PscW-1:0] pscQ;
  logic [MsW-1:0]  msQ;
  logic [1:0]      hitsQ, hitsD;
  logic [1:0]      dirQ, dirD;
  logic            junctionQ;
  logic            armedQ;
  logic            lineQ;

  logic       tick;
  logic       advanceDone, minPivotDone, seekTimeout, dirWaitDone;
  logic       start;
  logic       lineRise;
  logic [1:0] hitTarget;
  logic [1:0] hitsInc;
`ifdef JSEQ_BRAKE_SETTLE_EN
  logic       settleDone;
`endif

  // One ms tick; a phase of N ms expires on the last cycle of its N-th ms.
  assign tick         = (pscQ == PscW'(TickCycles - 1));
  assign advanceDone  = tick && (msQ == MsW'(ADVANCE_MS - 1));
  assign minPivotDone = tick && (msQ == MsW'(MIN_PIVOT_MS - 1));
  assign seekTimeout  = tick && (msQ == MsW'(PIVOT_TIMEOUT_MS - 1));
  assign dirWaitDone  = tick && (msQ == MsW'(DIR_WAIT_MS - 1));
`ifdef JSEQ_BRAKE_SETTLE_EN
  assign settleDone   = tick && (msQ == MsW'(SettleMs - 1));
`endif

  assign start     = (stateQ == StIdle) && junction && !junctionQ && armedQ && !abort;
  assign lineRise  = line_c && !lineQ;
  assign hitTarget = (dirQ == DirBack) ? 2'd2 : 2'd1;
  assign hitsInc   = hitsQ + 2'd1;

  always_comb begin
    stateD = stateQ;
    dirD   = dirQ;
    hitsD  = hitsQ;
    if (abort && (stateQ != StIdle)) begin
      stateD = StIdle;
    end else begin
      case (stateQ)
        StIdle: begin
          if (start) begin
            if (td_en) begin
              dirD   = td_dir;
              stateD = StAdvance;
            end else begin
              stateD = StWaitDir;
            end
          end
        end
        StWaitDir: begin
          // A direction arriving on the expiry cycle still wins.
          if (td_en) begin
            dirD   = td_dir;
            stateD = StAdvance;
          end else if (dirWaitDone) begin
            dirD   = DirStraight;
            stateD = StAdvance;
          end
        end
        StAdvance: begin
          if (advanceDone) begin
            if (dirQ == DirStraight) begin
              stateD = StDone;
            end else begin
              hitsD  = 2'd0;
`ifdef JSEQ_BRAKE_SETTLE_EN
              stateD = StSettle;
`else
              stateD = StPivotMin;
`endif
            end
          end
        end
        StPivotMin: begin
          if (minPivotDone) stateD = StPivotSeek;
        end
        StPivotSeek: begin
          // A hit beats a timeout in the same cycle.
          if (lineRise) begin
            hitsD = hitsInc;
            if (hitsInc >= hitTarget) begin
              stateD = StDone;
            end else begin
              // BACK: pivot blind again so the first line is cleared before the next count.
`ifdef JSEQ_BRAKE_SETTLE_EN
              stateD = StSettle;
`else
              stateD = StPivotMin;
`endif
            end
          end else if (seekTimeout) begin
            stateD = StFault;
          end
        end
`ifdef JSEQ_BRAKE_SETTLE_EN
        StSettle: begin
          if (settleDone) stateD = StPivotMin;
        end
`endif
        StDone:  stateD = StIdle;
        StFault: stateD = StIdle;
        default: stateD = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ    <= StIdle;
      pscQ      <= '0;
      msQ       <= '0;
      hitsQ     <= 2'd0;
      dirQ      <= 2'b00;
      junctionQ <= 1'b0;
      armedQ    <= 1'b1;
      lineQ     <= 1'b0;
    end else begin
      stateQ    <= stateD;
      hitsQ     <= hitsD;
      dirQ      <= dirD;
      junctionQ <= junction;
      lineQ     <= line_c;
      if (start) begin
        armedQ <= 1'b0;
      end else if (!junction) begin
        armedQ <= 1'b1;
      end
      // Timebase restarts on every state entry; idle keeps it parked at zero.
      if ((stateD != stateQ) || (stateQ == StIdle)) begin
        pscQ <= '0;
        msQ  <= '0;
      end else if (tick) begin
        pscQ <= '0;
        msQ  <= msQ + MsW'(1);
      end else begin
        pscQ <= pscQ + PscW'(1);
      end
    end
  end

  always_comb begin
    busy  = (stateQ != StIdle);
    done  = (stateQ == StDone);
    fault = (stateQ == StFault);
    mot_l = MotBrake;
    mot_r = MotBrake;
    case (stateQ)
      StAdvance: begin
        mot_l = MotFwd;
        mot_r = MotFwd;
      end
      StPivotMin, StPivotSeek: begin
        if (dirQ == DirLeft) begin
          mot_l = MotRev;
          mot_r = MotFwd;
        end else begin
          mot_l = MotFwd;
          mot_r = MotRev;
        end
      end
      default: begin
        mot_l = MotBrake;
        mot_r = MotBrake;
      end
    endcase
  end

  assign dir_q = dirQ;

endmodule

// File: tb/tb_junction_sequencer.sv
// Self-checking bench for junction_sequencer with 1 ms = 10 cycles.
module tb_junction_sequencer;

  logic       clk;
  logic       rst;
  logic       junction;
  logic       td_en;
  logic [1:0] td_dir;
  logic       line_c;
  logic       abort;
  logic       busy;
  logic       done;
  logic       fault;
  logic [1:0] mot_l;
  logic [1:0] mot_r;
  logic [1:0] dir_q;

  junction_sequencer #(
    .CLK_HZ          (10_000),
    .ADVANCE_MS      (5),
    .MIN_PIVOT_MS    (3),
    .PIVOT_TIMEOUT_MS(20),
    .DIR_WAIT_MS     (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .junction(junction),
    .td_en   (td_en),
    .td_dir  (td_dir),
    .line_c  (line_c),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .fault   (fault),
    .mot_l   (mot_l),
    .mot_r   (mot_r),
    .dir_q   (dir_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic       Hi = 1'b1;
  localparam logic       Lo = 1'b0;
  localparam logic [1:0] DS = 2'b00;
  localparam logic [1:0] DL = 2'b01;
  localparam logic [1:0] DR = 2'b10;
  localparam logic [1:0] DB = 2'b11;
  localparam logic [1:0] MB = 2'b00;
  localparam logic [1:0] MF = 2'b01;
  localparam logic [1:0] MR = 2'b10;

  // Expected vector layout: {busy, done, fault, mot_l, mot_r, dir_q}
  typedef struct {
    int unsigned cyc;
    logic        j;
    logic        en;
    logic [1:0]  dir;
    logic        line;
    logic        ab;
    logic [8:0]  exp;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  logic [8:0] obs;
  assign obs = {busy, done, fault, mot_l, mot_r, dir_q};

  task automatic add(input int unsigned c, input logic j, input logic en, input logic [1:0] d,
                     input logic ln, input logic ab, input logic bz, input logic dn,
                     input logic ft, input logic [1:0] ml, input logic [1:0] mr,
                     input logic [1:0] dq);
    vec_t v;
    v.cyc  = c;
    v.j    = j;
    v.en   = en;
    v.dir  = d;
    v.line = ln;
    v.ab   = ab;
    v.exp  = {bz, dn, ft, ml, mr, dq};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {busy,done,fault,motl,motr,dir}=%b required %b", name, act, exp);
    end
  endtask

  initial begin
    // STRAIGHT: 50 cycles forward, done, no retrigger while junction stays high.
    add(1,  Hi, Hi, DS, Lo, Lo, Hi, Lo, Lo, MF, MF, DS);
    add(49, Hi, Hi, DS, Lo, Lo, Hi, Lo, Lo, MF, MF, DS);
    add(1,  Hi, Hi, DS, Lo, Lo, Hi, Hi, Lo, MB, MB, DS);
    add(5,  Hi, Hi, DS, Lo, Lo, Lo, Lo, Lo, MB, MB, DS);
    add(2,  Lo, Lo, DS, Lo, Lo, Lo, Lo, Lo, MB, MB, DS);
    // LEFT: pivot (10,01); hit 10 cycles into PIVOT_SEEK.
    add(1,  Hi, Hi, DL, Lo, Lo, Hi, Lo, Lo, MF, MF, DL);
    add(49, Hi, Hi, DL, Lo, Lo, Hi, Lo, Lo, MF, MF, DL);
    add(30, Lo, Lo, DL, Lo, Lo, Hi, Lo, Lo, MR, MF, DL);
    add(10, Lo, Lo, DL, Lo, Lo, Hi, Lo, Lo, MR, MF, DL);
    add(1,  Lo, Lo, DL, Hi, Lo, Hi, Hi, Lo, MB, MB, DL);
    add(3,  Lo, Lo, DL, Lo, Lo, Lo, Lo, Lo, MB, MB, DL);
    // BACK: pulse in PIVOT_MIN ignored, hit 1 re-pivots, pulse in 2nd PIVOT_MIN ignored, hit 2.
    add(1,  Hi, Hi, DB, Lo, Lo, Hi, Lo, Lo, MF, MF, DB);
    add(49, Hi, Hi, DB, Lo, Lo, Hi, Lo, Lo, MF, MF, DB);
    add(10, Lo, Lo, DB, Lo, Lo, Hi, Lo, Lo, MF, MR, DB);
    add(5,  Lo, Lo, DB, Hi, Lo, Hi, Lo, Lo, MF, MR, DB);
    add(15, Lo, Lo, DB, Lo, Lo, Hi, Lo, Lo, MF, MR, DB);
    add(5,  Lo, Lo, DB, Lo, Lo, Hi, Lo, Lo, MF, MR, DB);
    add(3,  Lo, Lo, DB, Hi, Lo, Hi, Lo, Lo, MF, MR, DB);
    add(11, Lo, Lo, DB, Lo, Lo, Hi, Lo, Lo, MF, MR, DB);
    add(3,  Lo, Lo, DB, Hi, Lo, Hi, Lo, Lo, MF, MR, DB);
    add(17, Lo, Lo, DB, Lo, Lo, Hi, Lo, Lo, MF, MR, DB);
    add(1,  Lo, Lo, DB, Hi, Lo, Hi, Hi, Lo, MB, MB, DB);
    add(3,  Lo, Lo, DB, Lo, Lo, Lo, Lo, Lo, MB, MB, DB);
    // No direction: 40 braking cycles, then straight with dir_q forced to 00.
    add(1,  Hi, Lo, DR, Lo, Lo, Hi, Lo, Lo, MB, MB, DB);
    add(39, Hi, Lo, DR, Lo, Lo, Hi, Lo, Lo, MB, MB, DB);
    add(1,  Hi, Lo, DR, Lo, Lo, Hi, Lo, Lo, MF, MF, DS);
    add(49, Hi, Lo, DR, Lo, Lo, Hi, Lo, Lo, MF, MF, DS);
    add(1,  Hi, Lo, DR, Lo, Lo, Hi, Hi, Lo, MB, MB, DS);
    add(2,  Lo, Lo, DS, Lo, Lo, Lo, Lo, Lo, MB, MB, DS);
    // Timeout: RIGHT, line never seen, fault 200 cycles after PIVOT_SEEK entry.
    add(1,  Hi, Hi, DR, Lo, Lo, Hi, Lo, Lo, MF, MF, DR);
    add(49, Hi, Hi, DR, Lo, Lo, Hi, Lo, Lo, MF, MF, DR);
    add(30, Hi, Hi, DR, Lo, Lo, Hi, Lo, Lo, MF, MR, DR);
    add(200, Hi, Hi, DR, Lo, Lo, Hi, Lo, Lo, MF, MR, DR);
    add(1,  Hi, Hi, DR, Lo, Lo, Hi, Lo, Hi, MB, MB, DR);
    add(5,  Hi, Hi, DR, Lo, Lo, Lo, Lo, Lo, MB, MB, DR);
    add(2,  Lo, Lo, DR, Lo, Lo, Lo, Lo, Lo, MB, MB, DR);
    // Restart after junction went low, then abort mid-ADVANCE.
    add(1,  Hi, Hi, DS, Lo, Lo, Hi, Lo, Lo, MF, MF, DS);
    add(19, Hi, Hi, DS, Lo, Lo, Hi, Lo, Lo, MF, MF, DS);
    add(1,  Hi, Hi, DS, Lo, Hi, Lo, Lo, Lo, MB, MB, DS);
    add(3,  Hi, Hi, DS, Lo, Lo, Lo, Lo, Lo, MB, MB, DS);
    add(2,  Lo, Lo, DS, Lo, Lo, Lo, Lo, Lo, MB, MB, DS);
    // td_en on the DIR_WAIT expiry cycle: the tone direction wins.
    add(1,  Hi, Lo, DL, Lo, Lo, Hi, Lo, Lo, MB, MB, DS);
    add(39, Hi, Lo, DL, Lo, Lo, Hi, Lo, Lo, MB, MB, DS);
    add(1,  Hi, Hi, DL, Lo, Lo, Hi, Lo, Lo, MF, MF, DL);
    add(1,  Lo, Lo, DL, Lo, Hi, Lo, Lo, Lo, MB, MB, DL);
    add(2,  Lo, Lo, DL, Lo, Lo, Lo, Lo, Lo, MB, MB, DL);
    // Hit on the timeout cycle: done, not fault.
    add(1,  Hi, Hi, DR, Lo, Lo, Hi, Lo, Lo, MF, MF, DR);
    add(49, Hi, Hi, DR, Lo, Lo, Hi, Lo, Lo, MF, MF, DR);
    add(30, Hi, Hi, DR, Lo, Lo, Hi, Lo, Lo, MF, MR, DR);
    add(200, Hi, Hi, DR, Lo, Lo, Hi, Lo, Lo, MF, MR, DR);
    add(1,  Hi, Hi, DR, Hi, Lo, Hi, Hi, Lo, MB, MB, DR);
    add(2,  Lo, Lo, DR, Lo, Lo, Lo, Lo, Lo, MB, MB, DR);

    rst      = 1'b1;
    junction = 1'b0;
    td_en    = 1'b0;
    td_dir   = 2'b00;
    line_c   = 1'b0;
    abort    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", obs, 9'b0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      junction = vecs[i].j;
      td_en    = vecs[i].en;
      td_dir   = vecs[i].dir;
      line_c   = vecs[i].line;
      abort    = vecs[i].ab;
      for (int k = 0; k < int'(vecs[i].cyc); k++) begin
        @(posedge clk);
        #1;
        check($sformatf("vec%0d.cyc%0d", i, k), obs, vecs[i].exp);
      end
    end

    // Asynchronous reset in the middle of a LEFT pivot.
    junction = 1'b1;
    td_en    = 1'b1;
    td_dir   = DL;
    line_c   = 1'b0;
    abort    = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check("pivot_before_rst", obs, {Hi, Lo, Lo, MR, MF, DL});
    junction = 1'b0;
    td_en    = 1'b0;
    #2 rst = 1'b1;
    #1 check("rst_async", obs, 9'b0);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_idle", obs, 9'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/junction_sequencer.md
Name: junction_sequencer

Overview:
- Sequences the drive H-bridge through a complete junction manoeuvre: advance past the junction, pivot left/right/180 by tone-detector direction, reacquire the line, then return control.
- Sits between the tone-detection/line-sensor inputs and the drive state machine.
- While busy, its per-wheel commands override normal line following.
- Raises done or fault on completion.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency; sets the 1 ms tick prescale of CLK_HZ/1000 cycles.
- ADVANCE_MS, 200, forward drive time used to clear the junction.
- MIN_PIVOT_MS, 150, blind pivot time before the line sensor is sampled.
- PIVOT_TIMEOUT_MS, 2000, maximum time allowed in PIVOT_SEEK.
- DIR_WAIT_MS, 500, maximum wait for a valid tone direction.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- junction  in  1  junction detected (level)
- td_en  in  1  tone direction valid
- td_dir  in  2  00 STRAIGHT, 01 LEFT, 10 RIGHT, 11 BACK
- line_c  in  1  centre line sensor, 1 = on line
- abort  in  1  collision/abort request (level)
- busy  out  1  sequencer owns the motors
- done  out  1  one-cycle pulse on successful completion
- fault  out  1  one-cycle pulse on pivot timeout
- mot_l  out  2  left wheel command: 00 brake, 01 fwd, 10 rev, 11 never driven
- mot_r  out  2  right wheel command, same encoding as mot_l
- dir_q  out  2  latched manoeuvre direction

Behaviour:
- Reset: state IDLE, all outputs 0, prescaler/ms counter/hit counter 0, junction_q 0, armed 1.
- ms counter: the prescaler and ms counter clear on every state entry. A phase of N ms lasts exactly N*CLK_HZ/1000 cycles.
- Start condition: junction=1 and junction_q=0 and armed=1 and abort=0, sampled in IDLE.
  - busy goes high the next cycle.
  - armed clears on start and sets again only when junction=0.
  - A junction still high after completion does not retrigger.
- IDLE: mot_l=mot_r=00, busy=0.
  - On start with td_en=1: latch dir_q=td_dir and go to ADVANCE.
  - On start with td_en=0: go to WAIT_DIR.
- WAIT_DIR: motors brake.
  - td_en=1: latch td_dir and go to ADVANCE.
  - Ms counter reaches DIR_WAIT_MS: dir_q=STRAIGHT and go to ADVANCE.
- ADVANCE: mot_l=mot_r=01. After ADVANCE_MS:
  - dir_q=STRAIGHT goes to DONE.
  - Otherwise go to PIVOT_MIN. Hit target = 2 if BACK, else 1; hits cleared.
- Pivot polarity:
  - LEFT: mot_l=10, mot_r=01.
  - RIGHT and BACK: mot_l=01, mot_r=10.
- PIVOT_MIN: pivot with line_c ignored for MIN_PIVOT_MS, then go to PIVOT_SEEK.
- PIVOT_SEEK: pivot; a line_c rising edge (registered) increments hits.
  - hits reaches target: go to DONE.
  - hits below target after a hit: go back to PIVOT_MIN, so BACK clears the first line before counting the second.
  - Ms counter reaches PIVOT_TIMEOUT_MS: go to FAULT.
- DONE: brake, done=1 for one cycle, busy=1 in that cycle; next cycle IDLE.
- FAULT: brake, fault=1 for one cycle; next cycle IDLE.
- Abort:
  - abort=1 in any non-IDLE state gives brake outputs and IDLE on the next edge.
  - No done or fault pulse; busy drops that edge. abort has priority over all transitions.
- Simultaneous events in the same cycle:
  - Timeout and hit-target: the hit wins and the state goes to DONE.
  - td_en and DIR_WAIT_MS expiry: the td_dir value wins.
- Reset mid-operation: immediate return to reset values, motors 00.

Optional Feature:
- Macro JSEQ_BRAKE_SETTLE_EN.
- When defined, a SETTLE state holds mot_l=mot_r=00 for a fixed 30 ms:
  - between ADVANCE and PIVOT_MIN;
  - between PIVOT_SEEK and PIVOT_MIN on a BACK re-pivot.
- abort and reset apply in SETTLE as in any other state.
- When undefined, these transitions are direct and no SETTLE state or counter logic exists.

Test Plan:
- Tests use CLK_HZ=10_000 (1 ms = 10 cycles), ADVANCE_MS=5, MIN_PIVOT_MS=3, PIVOT_TIMEOUT_MS=20, DIR_WAIT_MS=4.
- STRAIGHT: junction rises with td_en=1, td_dir=00 -> busy next cycle, mot_l=mot_r=01 for exactly 50 cycles, then a one-cycle done, then IDLE with mot 00.
- LEFT: td_dir=01; line_c pulses high 10 cycles into PIVOT_SEEK -> advance 50 cycles, pivot (10,01) for 30+ cycles, done on the cycle after the registered edge.
- BACK: two line_c pulses, the first during PIVOT_MIN -> the first pulse is ignored; two counted hits in separate PIVOT_SEEK visits are required before done.
- No direction: td_en held 0 -> 40 braking cycles, then dir_q=00 and a straight advance, then done.
- Timeout: RIGHT with line_c held 0 -> fault pulse exactly 200 cycles after PIVOT_SEEK entry, done never asserts; junction held high afterwards gives no restart until it has been low.
- Abort: abort=1 mid-ADVANCE -> next edge mot 00, busy 0, no done or fault; rst asserted mid-pivot -> outputs 0 asynchronously.
